// File: rtl/packet_framer_stream.sv
// Store-and-forward packet framer: buffers one ingest packet, then emits a {seq,len}
// header, the payload and a constant or XOR-checksum footer under valid/ready flow control.
module packet_framer_stream #(
   parameter int                DATA_W      = 32,
   parameter int                MAX_WORDS   = 381,
   parameter int                SEQ_W       = 16,
   parameter int                LEN_W       = 16,
   parameter int                FOOTER_MODE = 0,
   parameter logic [DATA_W-1:0] FOOTER_VAL  = '1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              validIn,
   input  logic              lastIn,
   output logic              inReady,
   output logic [DATA_W-1:0] dataOut,
   output logic              validOut,
   output logic              lastOut,
   input  logic              outReady,
   output logic              dropPulse,
   output logic              busy
);

   localparam int               AW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_COLLECT,
      S_DISCARD,
      S_HEADER,
      S_PAYLOAD,
      S_FOOTER
   } t_state;

   t_state              r_state, w_state_nxt;
   logic [LEN_W-1:0]    r_wordCnt, w_wordCnt_nxt;
   logic [LEN_W-1:0]    r_len, w_len_nxt;
   logic [LEN_W-1:0]    r_rdIdx, w_rdIdx_nxt;
   logic [SEQ_W-1:0]    r_seq, w_seq_nxt;
   logic [DATA_W-1:0]   r_csum, w_csum_nxt;
   logic [DATA_W-1:0]   r_dataOut, w_dataOut_nxt;
   logic                r_validOut, w_validOut_nxt;
   logic                r_lastOut, w_lastOut_nxt;
   logic                r_drop, w_drop_nxt;
   logic                w_wr;
   logic [DATA_W-1:0]   r_buf [MAX_WORDS];

   function automatic logic [DATA_W-1:0] f_header(input logic [SEQ_W-1:0] seq,
                                                  input logic [LEN_W-1:0] len);
      logic [DATA_W-1:0] h;
      h = '0;
      h[LEN_W-1:0]             = len;
      h[SEQ_W+LEN_W-1:LEN_W]   = seq;
      return h;
   endfunction

   function automatic logic [DATA_W-1:0] f_footer(input logic [DATA_W-1:0] csum);
      return (FOOTER_MODE == 1) ? csum : FOOTER_VAL;
   endfunction

   always_comb begin
      w_state_nxt    = r_state;
      w_wordCnt_nxt  = r_wordCnt;
      w_len_nxt      = r_len;
      w_rdIdx_nxt    = r_rdIdx;
      w_seq_nxt      = r_seq;
      w_csum_nxt     = r_csum;
      w_dataOut_nxt  = r_dataOut;
      w_validOut_nxt = r_validOut;
      w_lastOut_nxt  = r_lastOut;
      w_drop_nxt     = 1'b0;
      w_wr           = 1'b0;
      case (r_state)
         S_COLLECT: begin
            if (validIn) begin
               // A beat arriving with the buffer already full makes the packet oversized.
               if (r_wordCnt == LP_MAX) begin
                  w_wordCnt_nxt = '0;
                  w_csum_nxt    = '0;
                  if (lastIn) w_drop_nxt  = 1'b1;
                  else        w_state_nxt = S_DISCARD;
               end else begin
                  w_wr          = 1'b1;
                  w_wordCnt_nxt = r_wordCnt + 1'b1;
                  w_csum_nxt    = r_csum ^ dataIn;
                  if (lastIn) begin
                     w_len_nxt      = r_wordCnt + 1'b1;
                     w_dataOut_nxt  = f_header(r_seq, r_wordCnt + 1'b1);
                     w_validOut_nxt = 1'b1;
                     w_state_nxt    = S_HEADER;
                  end
               end
            end
         end
         S_DISCARD: begin
            if (validIn && lastIn) begin
               w_drop_nxt    = 1'b1;
               w_wordCnt_nxt = '0;
               w_csum_nxt    = '0;
               w_state_nxt   = S_COLLECT;
            end
         end
         S_HEADER: begin
            if (outReady) begin
               w_dataOut_nxt = r_buf[0];
               w_rdIdx_nxt   = {{(LEN_W-1){1'b0}}, 1'b1};
               w_state_nxt   = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            // r_rdIdx is the index of the word to load on the next transfer.
            if (outReady) begin
               if (r_rdIdx == r_len) begin
                  w_dataOut_nxt = f_footer(r_csum);
                  w_lastOut_nxt = 1'b1;
                  w_state_nxt   = S_FOOTER;
               end else begin
                  w_dataOut_nxt = r_buf[r_rdIdx[AW-1:0]];
                  w_rdIdx_nxt   = r_rdIdx + 1'b1;
               end
            end
         end
         S_FOOTER: begin
            if (outReady) begin
               w_dataOut_nxt  = '0;
               w_validOut_nxt = 1'b0;
               w_lastOut_nxt  = 1'b0;
               w_seq_nxt      = r_seq + 1'b1;
               w_wordCnt_nxt  = '0;
               w_csum_nxt     = '0;
               w_state_nxt    = S_COLLECT;
            end
         end
         default: w_state_nxt = S_COLLECT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state    <= S_COLLECT;
         r_wordCnt  <= '0;
         r_len      <= '0;
         r_rdIdx    <= '0;
         r_seq      <= '0;
         r_csum     <= '0;
         r_dataOut  <= '0;
         r_validOut <= 1'b0;
         r_lastOut  <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wordCnt  <= w_wordCnt_nxt;
         r_len      <= w_len_nxt;
         r_rdIdx    <= w_rdIdx_nxt;
         r_seq      <= w_seq_nxt;
         r_csum     <= w_csum_nxt;
         r_dataOut  <= w_dataOut_nxt;
         r_validOut <= w_validOut_nxt;
         r_lastOut  <= w_lastOut_nxt;
         r_drop     <= w_drop_nxt;
      end
   end

   // Payload storage is never reset; stale contents are unreachable after reset.
   always_ff @(posedge clock) begin
      if (w_wr) r_buf[r_wordCnt[AW-1:0]] <= dataIn;
   end

   assign inReady   = (r_state == S_COLLECT) || (r_state == S_DISCARD);
   assign busy      = (r_state != S_COLLECT);
   assign dataOut   = r_dataOut;
   assign validOut  = r_validOut;
   assign lastOut   = r_lastOut;
   assign dropPulse = r_drop;

endmodule

// File: tb/tb_packet_framer_stream.sv
// Bench for packet_framer_stream: two configurations driven with directed and random
// packets; a packet-level model feeds per-instance expected queues popped by monitors.
module tb_packet_framer_stream;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int MW = (g == 0) ? 381 : 4;
      localparam int SW = (g == 0) ? 16 : 2;
      localparam int FM = (g == 0) ? 0 : 1;

      logic        resetn   = 1'b0;
      logic [31:0] dataIn   = '0;
      logic        validIn  = 1'b0;
      logic        lastIn   = 1'b0;
      logic        outReady = 1'b0;
      logic        inReady, validOut, lastOut, dropPulse, busy;
      logic [31:0] dataOut;

      logic [32:0] exp_q[$];
      int          m_seq     = 0;
      int          drop_exp  = 0;
      int          drop_seen = 0;
      int          xfer_cnt  = 0;
      int          rdy_mode  = 0;
      bit          rst_phase = 1'b0;
      bit          done      = 1'b0;

      packet_framer_stream #(
         .DATA_W(32), .MAX_WORDS(MW), .SEQ_W(SW), .LEN_W(16),
         .FOOTER_MODE(FM), .FOOTER_VAL(32'hFFFF_FFFF)
      ) u_dut (
         .clock(clock), .resetn(resetn), .dataIn(dataIn), .validIn(validIn),
         .lastIn(lastIn), .inReady(inReady), .dataOut(dataOut), .validOut(validOut),
         .lastOut(lastOut), .outReady(outReady), .dropPulse(dropPulse), .busy(busy)
      );

      // Downstream ready: 0 = always, 1 = 1,0,0 pattern, 2 = random.
      initial begin
         int ph = 0;
         forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
               0:       outReady = 1'b1;
               1:       begin outReady = (ph % 3 == 0); ph++; end
               default: outReady = 1'($urandom_range(0, 1));
            endcase
         end
      end

      initial begin
         logic [33:0] held    = '0;
         bit          stalled = 1'b0;
         forever begin
            @(negedge clock);
            if (rst_phase || !resetn) begin
               stalled = 1'b0;
            end else begin
               if (dropPulse) drop_seen++;
               if (stalled) chk("hold_stable", {validOut, lastOut, dataOut}, held);
               stalled = 1'b0;
               if (validOut) begin
                  chk("egress_inready", {busy, inReady}, 2'b10);
                  if (outReady) begin
                     xfer_cnt++;
                     if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                     else chk("egress_word", {lastOut, dataOut}, exp_q.pop_front());
                  end else begin
                     stalled = 1'b1;
                     held    = {validOut, lastOut, dataOut};
                  end
               end
            end
         end
      end

      task automatic wait_accept();
         int t = 0;
         @(negedge clock);
         while (!inReady && t < 2000) begin
            @(negedge clock);
            t++;
         end
         if (!inReady) chk("accept_timeout", 64'(inReady), 64'd1);
         @(posedge clock);
         #1;
      endtask

      task automatic send(input logic [31:0] w[$], input bit strict);
         int          n = w.size();
         logic [31:0] x = '0;
         logic [31:0] hdr;
         for (int i = 0; i < n; i++) begin
            if (!strict && $urandom_range(0, 3) == 0) begin
               validIn = 1'b0;
               @(posedge clock);
               #1;
            end
            dataIn  = w[i];
            validIn = 1'b1;
            lastIn  = (i == n - 1);
            wait_accept();
         end
         validIn = 1'b0;
         lastIn  = 1'b0;
         if (n > MW) begin
            drop_exp++;
            chk("drop_pulse", {dropPulse, validOut, inReady}, 3'b101);
         end else begin
            hdr = 32'((m_seq << 16) | n);
            exp_q.push_back({1'b0, hdr});
            foreach (w[i]) begin
               exp_q.push_back({1'b0, w[i]});
               x ^= w[i];
            end
            exp_q.push_back({1'b1, (FM == 1) ? x : 32'hFFFF_FFFF});
            m_seq = (m_seq + 1) % (1 << SW);
            chk("hdr_latency", {dropPulse, validOut, dataOut}, {2'b01, hdr});
            if (strict) begin
               for (int k = 1; k <= n + 1; k++) begin
                  @(posedge clock);
                  #1;
                  chk("no_bubble", 64'(validOut), 64'd1);
               end
               @(posedge clock);
               #1;
               chk("idle_after_footer", {validOut, lastOut, inReady, busy}, 4'b0010);
            end
         end
      endtask

      task automatic drain(input string nm);
         int t = 0;
         while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clock);
            #1;
            t++;
         end
         if (exp_q.size() != 0) chk(nm, 64'(exp_q.size()), 64'd0);
      endtask

      initial begin
         logic [31:0] pk[$];
         int          t;
         repeat (3) @(posedge clock);
         #1;
         chk("rst_outputs", {inReady, validOut, lastOut, dropPulse, busy, dataOut},
             {5'b10000, 32'h0});
         resetn   = 1'b1;
         rdy_mode = 0;
         repeat (2) @(posedge clock);
         #1;
         pk = '{32'hA1A1_0001, 32'hA1A1_0002, 32'hA1A1_0003};
         send(pk, 1'b1);
         pk = '{32'hB1B1_0001};
         send(pk, 1'b1);
         rdy_mode = 1;
         pk = '{32'hC0C0_0001, 32'hC0C0_0002, 32'hC0C0_0003, 32'hC0C0_0004};
         send(pk, 1'b0);
         rdy_mode = 0;
         pk = '{32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004, 32'hD0000005, 32'hD0000006};
         send(pk, 1'b0);
         pk = '{32'hE0000001, 32'hE0000002};
         send(pk, 1'b0);
         pk = '{32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 32'hF0000005};
         send(pk, 1'b0);
         pk = '{32'h0F0F_0F0F, 32'h00FF_00FF};
         send(pk, 1'b0);
         repeat (5) begin
            pk.delete();
            pk.push_back($urandom());
            send(pk, 1'b1);
         end
         rdy_mode = 2;
         repeat (30) begin
            pk.delete();
            t = $urandom_range(1, 7);
            repeat (t) pk.push_back($urandom());
            send(pk, 1'b0);
         end
         rdy_mode = 0;
         drain("drain_before_reset");
         pk = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
         send(pk, 1'b0);
         @(posedge clock);
         #1;
         chk("in_payload", {validOut, lastOut, dataOut}, {2'b10, 32'h1111_0001});
         rst_phase = 1'b1;
         resetn    = 1'b0;
         exp_q.delete();
         @(posedge clock);
         #1;
         chk("midpkt_reset", {inReady, validOut, lastOut, dropPulse, busy, dataOut},
             {5'b10000, 32'h0});
         resetn    = 1'b1;
         m_seq     = 0;
         exp_q.delete();
         rst_phase = 1'b0;
         pk = '{32'h2222_0001};
         send(pk, 1'b1);
         drain("drain_final");
         chk("drop_count", 64'(drop_seen), 64'(drop_exp));
         done = 1'b1;
      end
   end

   initial begin
      int t = 0;
      while (!(g_cfg[0].done && g_cfg[1].done) && t < 80000) begin
         @(posedge clock);
         t++;
      end
      if (!(g_cfg[0].done && g_cfg[1].done))
         chk("global_timeout", {g_cfg[0].done, g_cfg[1].done}, 2'b11);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
